// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared kinds, condition codes and payload types for branch resolution
package branch_pkg;

    typedef enum logic [1:0] {
        BR   = 2'd0,
        JAL  = 2'd1,
        JALR = 2'd2
    } br_kind_e;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    // Per-entry status bits carried alongside the target/link/redirect words.
    typedef struct packed {
        logic taken;
        logic illegal;
        logic misaligned;
        logic mispredict;
    } br_flags_t;

    // Only a taken transfer can fault; the alignment rule depends on compressed support.
    function automatic logic target_misaligned(input logic taken, input logic [1:0] lo,
                                               input logic c_ext);
        return taken & (c_ext ? lo[0] : (|lo));
    endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational conditional-branch evaluator
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o,
    output logic            illegal_o
);

    // Reserved encodings (2, 3) never take and are flagged illegal.
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (rs1_i == rs2_i);
            F3_BNE:  taken_o = (rs1_i != rs2_i);
            F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: taken_o = (rs1_i <  rs2_i);
            F3_BGEU: taken_o = (rs1_i >= rs2_i);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - pipelined branch/jump resolver; BRANCH_PERF_EN adds perf counters
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int C_EXT  = 0,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_illegal,
    output logic             out_misaligned
`ifdef BRANCH_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_resolved,
    output logic [CNT_W-1:0] perf_taken,
    output logic [CNT_W-1:0] perf_mispredict
`endif
);

    // Front end: direction, target and link straight from the operands.
    logic            cond_taken, cond_illegal;
    logic            taken_c, illegal_c;
    logic [XLEN-1:0] pc_plus_imm, jalr_sum, target_c, link_c;

    assign pc_plus_imm = in_pc + in_imm;
    assign jalr_sum    = in_rs1 + in_imm;
    assign link_c      = in_pc + {{(XLEN-3){1'b0}}, 3'b100};

    branch_cond #(.XLEN(XLEN)) u_cond (
        .funct3_i  (in_funct3),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .taken_o   (cond_taken),
        .illegal_o (cond_illegal)
    );

    // Select direction/target by kind; unknown kinds resolve like a conditional branch.
    always_comb begin
        taken_c   = cond_taken;
        illegal_c = cond_illegal;
        target_c  = pc_plus_imm;
        case (br_kind_e'(in_kind))
            JAL: begin
                taken_c   = 1'b1;
                illegal_c = 1'b0;
            end
            JALR: begin
                taken_c   = 1'b1;
                illegal_c = 1'b0;
                target_c  = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

    // Finish inputs: from the front end (1 stage) or from the stage-0 register (2 stages).
    logic            f_taken, f_illegal, f_pt;
    logic [XLEN-1:0] f_target, f_link, f_ptg;
    br_flags_t       fin_flags;
    logic [XLEN-1:0] fin_redirect;

    // Exceptions take priority over misprediction; a faulting entry never redirects as a mispredict.
    always_comb begin
        fin_flags.taken      = f_taken;
        fin_flags.illegal    = f_illegal;
        fin_flags.misaligned = target_misaligned(f_taken, f_target[1:0], C_EXT != 0);
        fin_flags.mispredict = ((f_taken != f_pt) | (f_taken & f_pt & (f_target != f_ptg)))
                               & ~f_illegal & ~fin_flags.misaligned;
        fin_redirect         = f_taken ? f_target : f_link;
    end

    // Output stage registers.
    logic            out_valid_q, out_valid_d;
    br_flags_t       out_flags_q, out_flags_d;
    logic [XLEN-1:0] out_target_q, out_target_d;
    logic [XLEN-1:0] out_link_q, out_link_d;
    logic [XLEN-1:0] out_redir_q, out_redir_d;
    logic            out_load, drain, accept;

    assign out_valid = out_valid_q & ~flush;
    assign drain     = out_valid & out_ready;
    assign accept    = in_valid & in_ready;

    if (STAGES == 2) begin : g_two
        logic            s0_valid_q, s0_valid_d;
        logic            s0_taken_q, s0_taken_d, s0_illegal_q, s0_illegal_d;
        logic            s0_pt_q, s0_pt_d;
        logic [XLEN-1:0] s0_target_q, s0_target_d, s0_link_q, s0_link_d;
        logic [XLEN-1:0] s0_ptg_q, s0_ptg_d;
        logic            s0_adv;

        assign s0_adv   = ~out_valid_q | drain;
        assign in_ready = (~s0_valid_q | s0_adv) & ~flush;
        assign out_load = s0_valid_q & s0_adv & ~flush;

        // Stage 0 captures condition/target/link plus the prediction it is checked against.
        always_comb begin
            s0_valid_d   = s0_valid_q;
            s0_taken_d   = s0_taken_q;
            s0_illegal_d = s0_illegal_q;
            s0_pt_d      = s0_pt_q;
            s0_target_d  = s0_target_q;
            s0_link_d    = s0_link_q;
            s0_ptg_d     = s0_ptg_q;
            if (flush) begin
                s0_valid_d = 1'b0;
            end else begin
                if (out_load) s0_valid_d = 1'b0;
                if (accept) begin
                    s0_valid_d   = 1'b1;
                    s0_taken_d   = taken_c;
                    s0_illegal_d = illegal_c;
                    s0_pt_d      = in_pred_taken;
                    s0_target_d  = target_c;
                    s0_link_d    = link_c;
                    s0_ptg_d     = in_pred_target;
                end
            end
        end

        // Stage 0 state register.
        always_ff @(posedge clk) begin
            if (rst) begin
                s0_valid_q   <= 1'b0;
                s0_taken_q   <= 1'b0;
                s0_illegal_q <= 1'b0;
                s0_pt_q      <= 1'b0;
                s0_target_q  <= '0;
                s0_link_q    <= '0;
                s0_ptg_q     <= '0;
            end else begin
                s0_valid_q   <= s0_valid_d;
                s0_taken_q   <= s0_taken_d;
                s0_illegal_q <= s0_illegal_d;
                s0_pt_q      <= s0_pt_d;
                s0_target_q  <= s0_target_d;
                s0_link_q    <= s0_link_d;
                s0_ptg_q     <= s0_ptg_d;
            end
        end

        assign f_taken   = s0_taken_q;
        assign f_illegal = s0_illegal_q;
        assign f_pt      = s0_pt_q;
        assign f_target  = s0_target_q;
        assign f_link    = s0_link_q;
        assign f_ptg     = s0_ptg_q;
    end else if (STAGES == 1) begin : g_one
        assign in_ready  = (~out_valid_q | drain) & ~flush;
        assign out_load  = accept;
        assign f_taken   = taken_c;
        assign f_illegal = illegal_c;
        assign f_pt      = in_pred_taken;
        assign f_target  = target_c;
        assign f_link    = link_c;
        assign f_ptg     = in_pred_target;
    end else begin : g_bad
        $error("branch_resolve_unit: STAGES must be 1 or 2");
    end

    // Output stage: load on advance, clear on drain or flush, otherwise hold stable.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_flags_d  = out_flags_q;
        out_target_d = out_target_q;
        out_link_d   = out_link_q;
        out_redir_d  = out_redir_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (out_load) begin
            out_valid_d  = 1'b1;
            out_flags_d  = fin_flags;
            out_target_d = f_target;
            out_link_d   = f_link;
            out_redir_d  = fin_redirect;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    // Output state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_flags_q  <= '0;
            out_target_q <= '0;
            out_link_q   <= '0;
            out_redir_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_flags_q  <= out_flags_d;
            out_target_q <= out_target_d;
            out_link_q   <= out_link_d;
            out_redir_q  <= out_redir_d;
        end
    end

    assign out_taken       = out_flags_q.taken;
    assign out_illegal     = out_flags_q.illegal;
    assign out_misaligned  = out_flags_q.misaligned;
    assign out_mispredict  = out_flags_q.mispredict;
    assign out_target      = out_target_q;
    assign out_link        = out_link_q;
    assign out_redirect_pc = out_redir_q;

`ifdef BRANCH_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [CNT_W-1:0] cnt_res_q, cnt_res_d, cnt_tkn_q, cnt_tkn_d, cnt_mp_q, cnt_mp_d;

    // Saturating event counters; flush does not touch them.
    always_comb begin
        cnt_res_d = cnt_res_q;
        cnt_tkn_d = cnt_tkn_q;
        cnt_mp_d  = cnt_mp_q;
        if (drain) begin
            if (cnt_res_q != '1)                   cnt_res_d = cnt_res_q + CNT_ONE;
            if (out_taken & (cnt_tkn_q != '1))     cnt_tkn_d = cnt_tkn_q + CNT_ONE;
            if (out_mispredict & (cnt_mp_q != '1)) cnt_mp_d  = cnt_mp_q + CNT_ONE;
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_res_q <= '0;
            cnt_tkn_q <= '0;
            cnt_mp_q  <= '0;
        end else begin
            cnt_res_q <= cnt_res_d;
            cnt_tkn_q <= cnt_tkn_d;
            cnt_mp_q  <= cnt_mp_d;
        end
    end

    assign perf_resolved   = cnt_res_q;
    assign perf_taken      = cnt_tkn_q;
    assign perf_mispredict = cnt_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench for branch_resolve_unit (2-stage and 1-stage builds)
module tb_branch_resolve_unit;

    typedef struct packed {
        logic        taken;
        logic        illegal;
        logic        misaligned;
        logic        mispredict;
        logic [31:0] target;
        logic [31:0] link;
        logic [31:0] redirect;
    } res_t;

    typedef struct packed {
        logic valid;
        logic ready;
        res_t r;
    } obs_t;

    logic        clk, rst, flush, in_valid, out_ready;
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm, ptg;
    logic        pt;

    logic        o_valid [2];
    logic        o_ready [2];
    logic        o_taken [2];
    logic        o_ill   [2];
    logic        o_mis   [2];
    logic        o_mp    [2];
    logic [31:0] o_target[2];
    logic [31:0] o_link  [2];
    logic [31:0] o_redir [2];
`ifdef BRANCH_PERF_EN
    logic [3:0]  p_res[2];
    logic [3:0]  p_tkn[2];
    logic [3:0]  p_mp [2];
`endif
    obs_t        obs[2];

    int   passed = 0;
    int   total  = 0;
    res_t q0[$];
    res_t q1[$];
    res_t last0, last1;
    int   n_out0 = 0;
    bit   rand_mode = 0;

    // Index 0: two stages, 4-byte alignment. Index 1: one stage, 2-byte alignment.
    branch_resolve_unit #(.XLEN(32), .STAGES(2), .C_EXT(0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[0]),
        .in_kind(kind), .in_funct3(f3), .in_rs1(rs1), .in_rs2(rs2), .in_pc(pc), .in_imm(imm),
        .in_pred_taken(pt), .in_pred_target(ptg), .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_taken(o_taken[0]), .out_target(o_target[0]), .out_link(o_link[0]),
        .out_mispredict(o_mp[0]), .out_redirect_pc(o_redir[0]), .out_illegal(o_ill[0]),
        .out_misaligned(o_mis[0])
`ifdef BRANCH_PERF_EN
        , .perf_resolved(p_res[0]), .perf_taken(p_tkn[0]), .perf_mispredict(p_mp[0])
`endif
    );

    branch_resolve_unit #(.XLEN(32), .STAGES(1), .C_EXT(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[1]),
        .in_kind(kind), .in_funct3(f3), .in_rs1(rs1), .in_rs2(rs2), .in_pc(pc), .in_imm(imm),
        .in_pred_taken(pt), .in_pred_target(ptg), .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_taken(o_taken[1]), .out_target(o_target[1]), .out_link(o_link[1]),
        .out_mispredict(o_mp[1]), .out_redirect_pc(o_redir[1]), .out_illegal(o_ill[1]),
        .out_misaligned(o_mis[1])
`ifdef BRANCH_PERF_EN
        , .perf_resolved(p_res[1]), .perf_taken(p_tkn[1]), .perf_mispredict(p_mp[1])
`endif
    );

    assign obs[0] = {o_valid[0], o_ready[0], o_taken[0], o_ill[0], o_mis[0], o_mp[0],
                     o_target[0], o_link[0], o_redir[0]};
    assign obs[1] = {o_valid[1], o_ready[1], o_taken[1], o_ill[1], o_mis[1], o_mp[1],
                     o_target[1], o_link[1], o_redir[1]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the architectural rules written out with plain modular arithmetic.
    function automatic res_t model(input logic [1:0] k, input logic [2:0] fn,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] p, input logic [31:0] im,
                                   input logic ptk, input logic [31:0] ptgt, input bit cext);
        res_t r;
        longint unsigned m = 64'h1_0000_0000;
        r = '0;
        r.link   = 32'((longint'(p) + 4) % m);
        r.target = 32'((longint'(p) + longint'(im)) % m);
        if (k == 2'd1) r.taken = 1'b1;
        else if (k == 2'd2) begin
            r.taken  = 1'b1;
            r.target = 32'((longint'(a) + longint'(im)) % m);
            if (r.target % 2 == 1) r.target = r.target - 1;
        end else begin
            case (fn)
                3'd0: r.taken = (a == b);
                3'd1: r.taken = (a != b);
                3'd4: r.taken = (int'(a) < int'(b));
                3'd5: r.taken = (int'(a) >= int'(b));
                3'd6: r.taken = (longint'(a) < longint'(b));
                3'd7: r.taken = (longint'(a) >= longint'(b));
                default: r.illegal = 1'b1;
            endcase
        end
        r.misaligned = r.taken && (cext ? (r.target % 2 != 0) : (r.target % 4 != 0));
        if (r.illegal || r.misaligned) r.mispredict = 1'b0;
        else if (r.taken != ptk)       r.mispredict = 1'b1;
        else                           r.mispredict = r.taken && (r.target != ptgt);
        r.redirect = r.taken ? r.target : r.link;
        return r;
    endfunction

    // One cycle: sample just after the falling edge, score handshakes, advance a full cycle.
    task automatic step(output bit acc0);
        res_t e;
        if (rand_mode) begin
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
        end
        #1;
        acc0 = !rst && in_valid && o_ready[0];
        for (int s = 0; s < 2; s++) begin
            if (!rst && in_valid && o_ready[s]) begin
                e = model(kind, f3, rs1, rs2, pc, imm, pt, ptg, s == 1);
                if (s == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (!rst && obs[s].valid && out_ready) begin
                total++;
                if ((s == 0 ? q0.size() : q1.size()) == 0) begin
                    $display("FAIL out_unexpected dut%0d: got output %h, expected none", s, obs[s].r);
                end else begin
                    e = (s == 0) ? q0.pop_front() : q1.pop_front();
                    if (obs[s].r !== e)
                        $display("FAIL out_result dut%0d: got %h, expected %h", s, obs[s].r, e);
                    else passed++;
                end
                if (s == 0) begin last0 = obs[0].r; n_out0++; end
                else last1 = obs[1].r;
            end
        end
        if (rst || flush) begin q0.delete(); q1.delete(); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] k, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                        input logic ptk, input logic [31:0] ptgt);
        bit acc = 0;
        kind = k; f3 = fn; rs1 = a; rs2 = b; pc = p; imm = im; pt = ptk; ptg = ptgt;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) step(acc);
        if (!acc) begin
            total++;
            $display("FAIL send_timeout: in_ready got 0 for 200 cycles, expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        rand_mode = 0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) step(acc);
        total++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL drain_timeout: pending got %0d/%0d, expected 0/0", q0.size(), q1.size());
        else passed++;
    endtask

    task automatic test_reset();
        bit   acc;
        obs_t exp;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rand_mode = 0;
        repeat (2) step(acc);
        #1;
        exp = '0;
        exp.ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (obs[s] !== exp) $display("FAIL reset_state dut%0d: got %h, expected %h", s, obs[s], exp);
            else passed++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_last(input string name, input res_t e0, input res_t e1);
        total += 2;
        if (last0 !== e0) $display("FAIL %s dut0: got %h, expected %h", name, last0, e0);
        else passed++;
        if (last1 !== e1) $display("FAIL %s dut1: got %h, expected %h", name, last1, e1);
        else passed++;
    endtask

    task automatic test_directed();
        res_t e;
        rand_mode = 0; out_ready = 1'b1;
        send(2'd0, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0); drain();
        e = {1'b1, 1'b0, 1'b0, 1'b1, 32'h120, 32'h104, 32'h120};
        check_last("blt_taken", e, e);
        send(2'd0, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0); drain();
        e = {1'b0, 1'b0, 1'b0, 1'b0, 32'h120, 32'h104, 32'h104};
        check_last("bltu_not_taken", e, e);
        send(2'd2, 3'd0, 32'h1001, 32'h0, 32'h200, 32'h2, 1'b1, 32'h1002); drain();
        check_last("jalr_align", {1'b1, 1'b0, 1'b1, 1'b0, 32'h1002, 32'h204, 32'h1002},
                                 {1'b1, 1'b0, 1'b0, 1'b0, 32'h1002, 32'h204, 32'h1002});
        send(2'd0, 3'd2, 32'h5, 32'h5, 32'h300, 32'h8, 1'b1, 32'h308); drain();
        e = {1'b0, 1'b1, 1'b0, 1'b0, 32'h308, 32'h304, 32'h304};
        check_last("illegal_f3", e, e);
        send(2'd1, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10); drain();
        e = {1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hFFFF_FFF4, 32'h10};
        check_last("jal_wrap", e, e);
    endtask

    task automatic test_random();
        res_t t;
        logic [1:0]  k;
        logic [2:0]  fn;
        logic [31:0] a, b, p, im, g;
        logic        ptk;
        for (int i = 0; i < 300; i++) begin
            rand_mode = 1;
            k   = 2'($urandom_range(0, 2));
            fn  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            p   = $urandom & 32'hFFFF_FFFC;
            im  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(12'($urandom)));
            ptk = 1'($urandom_range(0, 1));
            t   = model(k, fn, a, b, p, im, 1'b0, 32'h0, 1'b0);
            g   = ($urandom_range(0, 1) == 1) ? t.target : $urandom;
            send(k, fn, a, b, p, im, ptk, g);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bit   acc;
        int   sent = 0;
        int   start = n_out0;
        obs_t held;
        rand_mode = 0; flush = 1'b0;
        for (int c = 0; c < 40 && (sent < 4 || q0.size() != 0 || q1.size() != 0); c++) begin
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (sent < 4);
            kind = 2'd0; f3 = 3'd0; rs1 = 32'(sent); rs2 = 32'h1; pc = 32'h1000 + 32'(16 * sent);
            imm = 32'h40; pt = 1'b0; ptg = 32'h0;
            #1;
            if (c <= 4) begin
                total++;
                if (o_ready[0] !== (c < 2)) $display("FAIL b2b_in_ready c%0d: got %b, expected %b", c, o_ready[0], c < 2);
                else passed++;
            end
            if (c == 2) held = obs[0];
            if (c == 3 || c == 4) begin
                total++;
                if (obs[0] !== held) $display("FAIL b2b_hold c%0d: got %h, expected %h", c, obs[0], held);
                else passed++;
            end
            step(acc);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        total++;
        if (n_out0 - start != 4 || q0.size() != 0)
            $display("FAIL b2b_count: got %0d outputs, expected 4", n_out0 - start);
        else passed++;
    endtask

    task automatic test_flush();
        bit acc;
        rand_mode = 0; out_ready = 1'b0;
        send(2'd1, 3'd0, 32'h0, 32'h0, 32'h40, 32'h8, 1'b0, 32'h0);
        send(2'd1, 3'd0, 32'h0, 32'h0, 32'h80, 32'h8, 1'b0, 32'h0);
        flush = 1'b1; in_valid = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (obs[s].ready !== 1'b0 || obs[s].valid !== 1'b0)
                $display("FAIL flush_cycle dut%0d: got ready=%b valid=%b, expected 0 0", s, obs[s].ready, obs[s].valid);
            else passed++;
        end
        step(acc);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (obs[s].valid !== 1'b0) $display("FAIL flush_after dut%0d: got valid=%b, expected 0", s, obs[s].valid);
            else passed++;
        end
        repeat (4) step(acc);
    endtask

    task automatic test_reset_mid();
        bit acc;
        rand_mode = 0; out_ready = 1'b0;
        send(2'd1, 3'd0, 32'h0, 32'h0, 32'h40, 32'h8, 1'b0, 32'h0);
        send(2'd1, 3'd0, 32'h0, 32'h0, 32'h80, 32'h8, 1'b0, 32'h0);
        test_reset();
        out_ready = 1'b1;
        repeat (4) step(acc);
    endtask

`ifdef BRANCH_PERF_EN
    task automatic test_perf();
        test_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(2'd1, 3'd0, 32'h0, 32'h0, 32'h40, 32'h8, 1'b0, 32'h0);
        drain();
        for (int s = 0; s < 2; s++) begin
            total++;
            if (p_res[s] !== 4'hF || p_tkn[s] !== 4'hF || p_mp[s] !== 4'hF)
                $display("FAIL perf_sat dut%0d: got %h/%h/%h, expected f/f/f", s, p_res[s], p_tkn[s], p_mp[s]);
            else passed++;
        end
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        kind = 2'd0; f3 = 3'd0; rs1 = '0; rs2 = '0; pc = '0; imm = '0; pt = 1'b0; ptg = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
`ifdef BRANCH_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
